spring_sequencer: RTL and testbench
===================================

Name: spring_sequencer

Overview:
- Initiator-side partner of the spring force unit.
- Walks a table of NUM_SPRINGS vertex pairs and issues one spring request per pair (valid pulse, operands). Waits for each result_valid.
- Accumulates the returned force into per-vertex x/y accumulators: +F on vertex A, -F on vertex B.
- Sits between the soft-body vertex state and the velocity integrator, which consumes force_x_out/force_y_out after done_out.

Parameters:
- NUM_VERTICES, 4, number of vertices in the body.
- NUM_SPRINGS, 6, number of entries in the spring table.
- POSITION_SIZE, 8, signed width of vertex coordinates.
- VELOCITY_SIZE, 7, signed width of vertex velocities.
- FORCE_SIZE, 5, signed width of the spring-unit force result.
- ACC_SIZE, 10, signed width of the per-vertex force accumulators.
- WAIT_LIMIT, 255, maximum cycles spent waiting for one spring result before abort.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- start_in  in  1  one-cycle pulse that begins a pass; ignored while busy_out=1.
- pos_x_in, pos_y_in  in  [NUM_VERTICES] x POSITION_SIZE signed  vertex positions.
- vel_x_in, vel_y_in  in  [NUM_VERTICES] x VELOCITY_SIZE signed  vertex velocities.
- spring_a_in, spring_b_in  in  [NUM_SPRINGS] x clog2(NUM_VERTICES)  endpoint indices for each spring.
- spring_eq_in  in  [NUM_SPRINGS] x POSITION_SIZE  equilibrium length for each spring.
- spring_valid_out  out  1  request pulse to the spring unit (drives input_valid).
- v1_out, v2_out  out  [2] x POSITION_SIZE signed  endpoint positions, element 0 = x, element 1 = y.
- vel1_x_out, vel1_y_out, vel2_x_out, vel2_y_out  out  VELOCITY_SIZE signed  endpoint velocities.
- equilibrium_out  out  POSITION_SIZE  equilibrium length for the current spring.
- spring_force_x_in, spring_force_y_in  in  FORCE_SIZE signed  spring-unit result; this is the force on v1.
- spring_done_in  in  1  spring-unit result_valid.
- force_x_out, force_y_out  out  [NUM_VERTICES] x ACC_SIZE signed  accumulated per-vertex force.
- busy_out  out  1  high from the cycle after start_in accepted until return to IDLE.
- done_out  out  1  one-cycle pulse when a pass completes successfully.
- error_out  out  1  sticky flag set on timeout; cleared by the next accepted start_in.

Behaviour:
- Reset: all outputs 0, accumulators 0, FSM in IDLE, spring index 0.
- States: IDLE, CLEAR, ISSUE, WAIT, ACCUM, FINISH.
- IDLE: on start_in go to CLEAR; error_out is cleared.
- CLEAR: zero all accumulators, set idx=0, go to ISSUE.
- ISSUE:
  - If spring_a[idx]==spring_b[idx] (degenerate spring): no request; advance idx, or go to FINISH if idx was the last entry.
  - Otherwise: register operands from the tables and vertex arrays, assert spring_valid_out for exactly this one cycle, go to WAIT.
- Operand outputs hold their values from ISSUE through WAIT.
- WAIT: count cycles.
  - spring_done_in → capture both force components, go to ACCUM.
  - Count reaches WAIT_LIMIT → set error_out, go to IDLE with no done_out; accumulators keep partial values.
- ACCUM (one cycle):
  - acc[A] += sext(Fx), acc[B] -= sext(Fx); same for y.
  - Each add saturates to the signed ACC_SIZE range.
  - Then idx==NUM_SPRINGS-1 → FINISH, else idx++ and go to ISSUE.
- FINISH: done_out=1 for one cycle, then IDLE.
- force_*_out hold their values until the next CLEAR.
- Latency, S non-degenerate springs each with spring-unit latency L: done_out rises 2 + S*(L+2) + D cycles after start_in, where D = count of degenerate springs. Accumulators are readable in the same cycle as done_out.
- Multiple springs touching the same vertex accumulate sequentially; no conflicts.
- spring_done_in outside WAIT is ignored.
- start_in while busy is ignored.
- Inputs may change while busy: operands are sampled only in ISSUE.
- rst_in mid-pass: immediate return to the reset state.

Decomposition:
- Package spring_pkg: FSM state enum, index-width constant (clog2 of NUM_VERTICES), saturating-add function.
- One sub-module, force_accumulator: register file of 2*NUM_VERTICES accumulators with clear, dual-index saturating add/subtract, and parallel read-out. The FSM stays in spring_sequencer.

Test Plan:
The bench uses a spring-unit model that responds after 5 cycles with programmable forces.
1. Single spring 0→1, model returns F=(3,-2), all other springs degenerate → force_x_out[0]=3, force_y_out[0]=-2, force_x_out[1]=-3, force_y_out[1]=2; exactly one spring_valid_out pulse; done_out at the computed latency.
2. Chain 0-1, 1-2, 2-3 with F=(1,1) each → force on vertex 0 = (1,1), vertices 1 and 2 = (0,0), vertex 3 = (-1,-1).
3. Model returns -16 for 60 springs all on pair 0-1 (NUM_SPRINGS=60 instance) → acc[0] saturates at -512, acc[1] at +511; no wrap.
4. Model never asserts done → error_out=1 after 255 WAIT cycles; busy_out falls; no done_out. A new start_in clears error_out.
5. start_in pulsed during WAIT, and spurious spring_done_in while in IDLE → both ignored; results match a clean run.
6. rst_in asserted during WAIT → all outputs 0 immediately. A subsequent start completes normally.

Source files
------------

// File: rtl/spring_pkg.sv
// spring_pkg: shared FSM states, index-width helper and saturating add for the spring sequencer
package spring_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, ACCUM, FINISH} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b, input int w);
    logic signed [32:0] s, hi, lo;
    s = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -hi - 33'sd1;
    return (s > hi) ? hi[31:0] : (s < lo) ? lo[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/force_accumulator.sv
// force_accumulator: per-vertex x/y force registers with clear, +F on A / -F on B saturating update
module force_accumulator
  import spring_pkg::*;
#(
  parameter int NUM_VERTICES = 4,
  parameter int FORCE_SIZE = 5,
  parameter int ACC_SIZE = 10,
  parameter int VW = idx_w(NUM_VERTICES)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_add,
  input  logic [VW-1:0]              i_a,
  input  logic [VW-1:0]              i_b,
  input  logic signed [FORCE_SIZE-1:0] i_fx,
  input  logic signed [FORCE_SIZE-1:0] i_fy,
  output logic signed [ACC_SIZE-1:0] o_x [NUM_VERTICES],
  output logic signed [ACC_SIZE-1:0] o_y [NUM_VERTICES]
);
  logic signed [ACC_SIZE-1:0] r_x [NUM_VERTICES];
  logic signed [ACC_SIZE-1:0] r_y [NUM_VERTICES];
  assign o_x = r_x;
  assign o_y = r_y;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      for (int i = 0; i < NUM_VERTICES; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VERTICES; i++)
        if (i_clear) begin
          r_x[i] <= '0;
          r_y[i] <= '0;
        end else if (i_add && (VW'(i) == i_a || VW'(i) == i_b)) begin
          r_x[i] <= ACC_SIZE'(sat_add(32'(r_x[i]), VW'(i) == i_a ? 32'(i_fx) : -32'(i_fx), ACC_SIZE));
          r_y[i] <= ACC_SIZE'(sat_add(32'(r_y[i]), VW'(i) == i_a ? 32'(i_fy) : -32'(i_fy), ACC_SIZE));
        end
    end
endmodule

// File: rtl/spring_sequencer.sv
// spring_sequencer: walks the spring table, issues one request per spring and accumulates per-vertex forces
module spring_sequencer
  import spring_pkg::*;
#(
  parameter int NUM_VERTICES = 4,
  parameter int NUM_SPRINGS = 6,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 7,
  parameter int FORCE_SIZE = 5,
  parameter int ACC_SIZE = 10,
  parameter int WAIT_LIMIT = 255,
  parameter int VW = idx_w(NUM_VERTICES)
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            start_in,
  input  logic signed [POSITION_SIZE-1:0] pos_x_in [NUM_VERTICES],
  input  logic signed [POSITION_SIZE-1:0] pos_y_in [NUM_VERTICES],
  input  logic signed [VELOCITY_SIZE-1:0] vel_x_in [NUM_VERTICES],
  input  logic signed [VELOCITY_SIZE-1:0] vel_y_in [NUM_VERTICES],
  input  logic [VW-1:0]                   spring_a_in [NUM_SPRINGS],
  input  logic [VW-1:0]                   spring_b_in [NUM_SPRINGS],
  input  logic [POSITION_SIZE-1:0]        spring_eq_in [NUM_SPRINGS],
  output logic                            spring_valid_out,
  output logic signed [POSITION_SIZE-1:0] v1_out [2],
  output logic signed [POSITION_SIZE-1:0] v2_out [2],
  output logic signed [VELOCITY_SIZE-1:0] vel1_x_out,
  output logic signed [VELOCITY_SIZE-1:0] vel1_y_out,
  output logic signed [VELOCITY_SIZE-1:0] vel2_x_out,
  output logic signed [VELOCITY_SIZE-1:0] vel2_y_out,
  output logic [POSITION_SIZE-1:0]        equilibrium_out,
  input  logic signed [FORCE_SIZE-1:0]    spring_force_x_in,
  input  logic signed [FORCE_SIZE-1:0]    spring_force_y_in,
  input  logic                            spring_done_in,
  output logic signed [ACC_SIZE-1:0]      force_x_out [NUM_VERTICES],
  output logic signed [ACC_SIZE-1:0]      force_y_out [NUM_VERTICES],
  output logic                            busy_out,
  output logic                            done_out,
  output logic                            error_out
);
  localparam int SW = idx_w(NUM_SPRINGS);
  localparam int CW = idx_w(WAIT_LIMIT + 1);
  localparam int OW = 5 * POSITION_SIZE + 4 * VELOCITY_SIZE;
  state_t r_state, w_next;
  logic [SW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic [VW-1:0] w_a, w_b, r_a, r_b;
  logic [OW-1:0] w_op, r_op, w_out;
  logic signed [FORCE_SIZE-1:0] r_fx, r_fy;
  logic r_err, w_degen, w_last, w_timeout, w_step;
  assign w_a = spring_a_in[r_idx];
  assign w_b = spring_b_in[r_idx];
  assign w_degen = w_a == w_b;
  assign w_last = r_idx == SW'(NUM_SPRINGS - 1);
  assign w_timeout = r_cnt == CW'(WAIT_LIMIT - 1);
  assign w_step = !w_last && ((r_state == ISSUE && w_degen) || r_state == ACCUM);
  assign w_op = {pos_x_in[w_a], pos_y_in[w_a], pos_x_in[w_b], pos_y_in[w_b],
                 vel_x_in[w_a], vel_y_in[w_a], vel_x_in[w_b], vel_y_in[w_b], spring_eq_in[r_idx]};
  // operands are live during ISSUE (so they line up with the request) and held from the capture afterwards
  assign w_out = r_state == ISSUE ? w_op : r_op;
  assign {v1_out[0], v1_out[1], v2_out[0], v2_out[1],
          vel1_x_out, vel1_y_out, vel2_x_out, vel2_y_out, equilibrium_out} = w_out;
  assign spring_valid_out = r_state == ISSUE && !w_degen;
  assign busy_out = r_state != IDLE;
  assign done_out = r_state == FINISH;
  assign error_out = r_err;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start_in ? CLEAR : IDLE;
      CLEAR:   w_next = ISSUE;
      ISSUE:   w_next = !w_degen ? WAIT : w_last ? FINISH : ISSUE;
      WAIT:    w_next = spring_done_in ? ACCUM : w_timeout ? IDLE : WAIT;
      ACCUM:   w_next = w_last ? FINISH : ISSUE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_fx <= '0;
      r_fy <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx <= r_state == CLEAR ? '0 : w_step ? r_idx + 1'b1 : r_idx;
      r_cnt <= r_state == WAIT ? r_cnt + 1'b1 : '0;
      if (r_state == IDLE && start_in) r_err <= 1'b0;
      if (r_state == WAIT && !spring_done_in && w_timeout) r_err <= 1'b1;
      if (r_state == ISSUE && !w_degen) begin
        r_a <= w_a;
        r_b <= w_b;
        r_op <= w_op;
      end
      if (r_state == WAIT && spring_done_in) begin
        r_fx <= spring_force_x_in;
        r_fy <= spring_force_y_in;
      end
    end
  force_accumulator #(
    .NUM_VERTICES(NUM_VERTICES), .FORCE_SIZE(FORCE_SIZE), .ACC_SIZE(ACC_SIZE), .VW(VW)
  ) u_acc (
    .i_clk(clk_in), .i_rst(rst_in), .i_clear(r_state == CLEAR), .i_add(r_state == ACCUM),
    .i_a(r_a), .i_b(r_b), .i_fx(r_fx), .i_fy(r_fy), .o_x(force_x_out), .o_y(force_y_out)
  );
endmodule

// File: tb/tb_spring_sequencer.sv
// tb_spring_sequencer: table-driven directed checks against a 5-cycle spring-unit model
module tb_spring_sequencer;
  typedef struct {
    int a [6];
    int b [6];
    int fx, fy;
    int ex [4];
    int ey [4];
    int lat, pulses;
  } vec_t;
  vec_t vt [6];
  int checks = 0, failures = 0;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic signed [7:0] pos_x [4], pos_y [4];
  logic signed [6:0] vel_x [4], vel_y [4];
  logic [1:0] sa [6], sb [6], sa6 [60], sb6 [60];
  logic [7:0] eqt [6], eqt6 [60];
  logic start = 0, start6 = 0, inj = 0, men = 1;
  logic signed [4:0] mfx = 0, mfy = 0, m6x = -5'sd16, m6y = 5'sd15;
  logic [4:0] sr, sr6;
  logic dvalid, ddone, busy, done, err, dvalid6, ddone6, busy6, done6, err6;
  logic signed [7:0] v1 [2], v2 [2], v1_6 [2], v2_6 [2];
  logic signed [6:0] ve1x, ve1y, ve2x, ve2y, ve1x6, ve1y6, ve2x6, ve2y6;
  logic [7:0] eq, eq6;
  logic signed [9:0] fx [4], fy [4], fx6 [4], fy6 [4];

  spring_sequencer dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .pos_x_in(pos_x), .pos_y_in(pos_y), .vel_x_in(vel_x), .vel_y_in(vel_y),
    .spring_a_in(sa), .spring_b_in(sb), .spring_eq_in(eqt),
    .spring_valid_out(dvalid), .v1_out(v1), .v2_out(v2),
    .vel1_x_out(ve1x), .vel1_y_out(ve1y), .vel2_x_out(ve2x), .vel2_y_out(ve2y),
    .equilibrium_out(eq), .spring_force_x_in(mfx), .spring_force_y_in(mfy),
    .spring_done_in(ddone), .force_x_out(fx), .force_y_out(fy),
    .busy_out(busy), .done_out(done), .error_out(err)
  );

  spring_sequencer #(.NUM_SPRINGS(60)) dut60 (
    .clk_in(clk), .rst_in(rst), .start_in(start6),
    .pos_x_in(pos_x), .pos_y_in(pos_y), .vel_x_in(vel_x), .vel_y_in(vel_y),
    .spring_a_in(sa6), .spring_b_in(sb6), .spring_eq_in(eqt6),
    .spring_valid_out(dvalid6), .v1_out(v1_6), .v2_out(v2_6),
    .vel1_x_out(ve1x6), .vel1_y_out(ve1y6), .vel2_x_out(ve2x6), .vel2_y_out(ve2y6),
    .equilibrium_out(eq6), .spring_force_x_in(m6x), .spring_force_y_in(m6y),
    .spring_done_in(ddone6), .force_x_out(fx6), .force_y_out(fy6),
    .busy_out(busy6), .done_out(done6), .error_out(err6)
  );

  // spring-unit models: result_valid five cycles after the request
  always @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else sr <= {sr[3:0], dvalid & men};
  always @(posedge clk or posedge rst)
    if (rst) sr6 <= '0;
    else sr6 <= {sr6[3:0], dvalid6};
  assign ddone = sr[4] | inj;
  assign ddone6 = sr6[4];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic load(input int k);
    for (int i = 0; i < 6; i++) begin
      sa[i] = 2'(vt[k].a[i]);
      sb[i] = 2'(vt[k].b[i]);
    end
    mfx = 5'(vt[k].fx);
    mfy = 5'(vt[k].fy);
  endtask

  task automatic run(input int k, input int xs, input string tag);
    int n, dn, pulses, fj;
    bit seen;
    load(k);
    fj = -1;
    for (int j = 0; j < 6; j++) if (fj < 0 && vt[k].a[j] != vt[k].b[j]) fj = j;
    @(negedge clk);
    start = 1;
    n = 0; dn = 0; pulses = 0; seen = 0;
    while (dn == 0 && n < 600) begin
      @(posedge clk);
      n++;
      #1;
      start = (n == xs);
      if (n == 1) chk({tag, "_err_clr"}, int'(err), 0);
      if (dvalid) begin
        pulses++;
        if (!seen && fj >= 0) begin
          seen = 1;
          chk({tag, "_op_v1x"}, int'(v1[0]), int'(pos_x[vt[k].a[fj]]));
          chk({tag, "_op_v2y"}, int'(v2[1]), int'(pos_y[vt[k].b[fj]]));
          chk({tag, "_op_eq"}, int'(eq), int'(eqt[fj]));
        end
      end
      if (done) dn = n;
    end
    start = 0;
    chk({tag, "_latency"}, dn, vt[k].lat);
    chk({tag, "_pulses"}, pulses, vt[k].pulses);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_fx%0d", tag, i), int'(fx[i]), vt[k].ex[i]);
      chk($sformatf("%s_fy%0d", tag, i), int'(fy[i]), vt[k].ey[i]);
    end
    @(posedge clk);
    #1;
    chk({tag, "_done_1cyc"}, int'(done), 0);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int n, en, dc;
    for (int i = 0; i < 4; i++) begin
      pos_x[i] = 8'(13 * i - 20);
      pos_y[i] = 8'(7 * i + 3);
      vel_x[i] = 7'(i - 2);
      vel_y[i] = 7'(5 - i);
    end
    for (int i = 0; i < 6; i++) eqt[i] = 8'(20 + 10 * i);
    for (int i = 0; i < 60; i++) begin
      sa6[i] = 2'd0;
      sb6[i] = 2'd1;
      eqt6[i] = 8'(i);
    end
    vt[0] = '{a:'{0,2,2,2,2,2}, b:'{1,2,2,2,2,2}, fx:3, fy:-2, ex:'{3,-3,0,0}, ey:'{-2,2,0,0}, lat:14, pulses:1};
    vt[1] = '{a:'{0,1,2,3,3,3}, b:'{1,2,3,3,3,3}, fx:1, fy:1, ex:'{1,0,0,-1}, ey:'{1,0,0,-1}, lat:26, pulses:3};
    vt[2] = '{a:'{0,0,0,1,1,1}, b:'{1,2,3,1,1,1}, fx:2, fy:3, ex:'{6,-2,-2,-2}, ey:'{9,-3,-3,-3}, lat:26, pulses:3};
    vt[3] = '{a:'{0,1,2,3,0,1}, b:'{0,1,2,3,0,1}, fx:7, fy:7, ex:'{0,0,0,0}, ey:'{0,0,0,0}, lat:8, pulses:0};
    vt[4] = '{a:'{1,1,1,1,1,2}, b:'{1,1,1,1,1,3}, fx:-5, fy:4, ex:'{0,0,-5,5}, ey:'{0,0,4,-4}, lat:14, pulses:1};
    vt[5] = '{a:'{3,3,3,3,3,3}, b:'{0,0,0,0,0,0}, fx:-16, fy:15, ex:'{96,0,0,-96}, ey:'{-90,0,0,90}, lat:44, pulses:6};
    load(0);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_valid", int'(dvalid), 0);
    chk("rst_v1x", int'(v1[0]), 0);
    chk("rst_fx0", int'(fx[0]), 0);
    chk("rst_busy60", int'(busy6), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    run(0, -1, "single");
    run(1, -1, "chain");
    run(2, -1, "star");
    run(3, -1, "all_degen");
    run(4, -1, "last_only");
    run(5, -1, "six_same");
    // spurious results while idle must not disturb the held accumulators
    @(negedge clk);
    mfx = 5'sd9;
    inj = 1;
    repeat (2) @(negedge clk);
    inj = 0;
    chk("spur_busy", int'(busy), 0);
    chk("spur_fx0", int'(fx[0]), vt[5].ex[0]);
    chk("spur_fy3", int'(fy[3]), vt[5].ey[3]);
    run(1, 4, "start_in_wait");
    run(2, 2, "start_in_issue");
    // timeout: the model stays silent
    load(0);
    men = 0;
    @(negedge clk);
    start = 1;
    n = 0; en = 0; dc = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      #1;
      start = 0;
      if (done) dc++;
      if (err && en == 0) en = n;
      if (!busy) break;
    end
    chk("to_idle_cycle", n, 258);
    chk("to_err_cycle", en, 258);
    chk("to_err", int'(err), 1);
    chk("to_no_done", dc, 0);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", int'(err), 1);
    men = 1;
    run(0, -1, "post_err");
    // asynchronous reset while waiting on a result
    load(0);
    @(negedge clk);
    start = 1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      start = 0;
    end
    chk("hold_v1x", int'(v1[0]), int'(pos_x[0]));
    chk("hold_busy", int'(busy), 1);
    rst = 1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_v1x", int'(v1[0]), 0);
    chk("mid_rst_v2y", int'(v2[1]), 0);
    chk("mid_rst_fx0", int'(fx[0]), 0);
    @(negedge clk);
    rst = 0;
    run(1, -1, "post_rst");
    // 60-spring instance: accumulators must clamp, never wrap
    @(negedge clk);
    start6 = 1;
    n = 0; en = 0;
    while (en == 0 && n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      start6 = 0;
      if (done6) en = n;
    end
    chk("sat_latency", en, 422);
    chk("sat_fx0", int'(fx6[0]), -512);
    chk("sat_fx1", int'(fx6[1]), 511);
    chk("sat_fy0", int'(fy6[0]), 511);
    chk("sat_fy1", int'(fy6[1]), -512);
    chk("sat_fx2", int'(fx6[2]), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
